// File: rtl/civic_pkg.sv
// Shared definitions for the FPGA root-of-trust core: message opcodes, NVRAM map and FSM encodings.
package civic_pkg;

    localparam int KEY_WORDS  = 8;
    localparam int CERT_WORDS = 8;

    // Word index covers the larger buffer; a count needs one more bit to hold that size.
    localparam int IDX_W = $clog2((KEY_WORDS > CERT_WORDS) ? KEY_WORDS : CERT_WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [31:0] EK_PRIV_BASE = 32'h0000_1000;
    localparam logic [31:0] EK_PUB_BASE  = 32'h0000_2000;
    localparam logic [31:0] CERT_BASE    = 32'h0000_3000;
    localparam logic [31:0] REF_ADDR     = 32'h0000_0000;
    localparam logic [31:0] LOG_ADDR     = 32'h0000_4000;

    localparam logic [31:0] MSG_AUTH_REQUEST  = 32'h0000_0001;
    localparam logic [31:0] MSG_CERT_RESPONSE = 32'h0000_0002;
    localparam logic [31:0] MSG_CONFIG_WRITE  = 32'h0000_0003;
    localparam logic [31:0] MSG_ERROR         = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_WAIT_KEY,
        ST_RD_REF,
        ST_RD_PRIV,
        ST_RD_PUB,
        ST_RD_CERT,
        ST_CHECK,
        ST_LOG,
        ST_READY,
        ST_FAIL
    } boot_state_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_REQ,
        LD_WAIT
    } ld_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_TX,
        P_ERR,
        P_ADDR,
        P_DATA
    } proto_state_t;

    typedef struct packed {
        boot_state_t  boot;
        ld_state_t    ld;
        proto_state_t proto;
    } dbg_t;

    // Key word i of the 256-bit device key; word 0 is key[31:0].
    function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] i);
        return key[i*32 +: 32];
    endfunction

endpackage

// File: rtl/civic_fpga_rot_core_if.sv
// Tenant word stream and NVRAM port of the root-of-trust core.
// Handshake: a *_valid / *_en is a single-cycle qualifier for its data in that same cycle;
// there is no ready/backpressure anywhere, and a read returns exactly one nvram_rd_valid pulse.
interface civic_fpga_rot_core_if;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic [31:0] nvram_rd_addr;
    logic        nvram_rd_en;
    logic [31:0] nvram_rd_data;
    logic        nvram_rd_valid;
    logic [31:0] nvram_wr_addr;
    logic        nvram_wr_en;
    logic [31:0] nvram_wr_data;

    modport master (
        input  rx_data, rx_valid, nvram_rd_data, nvram_rd_valid,
        output tx_data, tx_valid, nvram_rd_addr, nvram_rd_en,
               nvram_wr_addr, nvram_wr_en, nvram_wr_data
    );

    modport slave (
        output rx_data, rx_valid, nvram_rd_data, nvram_rd_valid,
        input  tx_data, tx_valid, nvram_rd_addr, nvram_rd_en,
               nvram_wr_addr, nvram_wr_en, nvram_wr_data
    );
endinterface

// File: rtl/civic_nvram_loader.sv
// Sequential NVRAM reader: fetches count words from base, one outstanding read at a time.
module civic_nvram_loader
    import civic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [CNT_W-1:0] count,
    output logic             rd_en,
    output logic [31:0]      rd_addr,
    input  logic [31:0]      rd_data,
    input  logic             rd_valid,
    output logic             word_valid,
    output logic [31:0]      word_data,
    output logic [IDX_W-1:0] word_idx,
    output logic             done,
    output ld_state_t        state
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ld_state_t        state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_word;
    logic             accept;

    assign last_word = (state_q == LD_WAIT) && rd_valid && ({1'b0, idx_q} == (count_q - CNT_ONE));
    // A new job may start in the same cycle the previous one delivers its last word.
    assign accept    = start && ((state_q == LD_IDLE) || last_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LD_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        if (accept) begin
            base_d  = base;
            count_d = count;
            idx_d   = '0;
            state_d = LD_REQ;
        end else begin
            case (state_q)
                LD_REQ:  state_d = LD_WAIT;
                LD_WAIT: begin
                    if (last_word) begin
                        state_d = LD_IDLE;
                    end else if (rd_valid) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LD_REQ;
                    end
                end
                default: state_d = LD_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en      = (state_q == LD_REQ);
        rd_addr    = rd_en ? (base_q + 32'({idx_q, 2'b00})) : '0;
        word_valid = (state_q == LD_WAIT) && rd_valid;
        word_data  = word_valid ? rd_data : '0;
        word_idx   = idx_q;
        done       = last_word;
        state      = state_q;
    end

endmodule

// File: rtl/civic_fpga_rot_core.sv
// FPGA root-of-trust core: latches the eFUSE key, loads and measures EK material from NVRAM,
// then serves the tenant AUTH/CONFIG protocol once the measurement matches the reference.
module civic_fpga_rot_core
    import civic_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    civic_fpga_rot_core_if.master bus,
    input  logic                  efuse_key_ready,
    input  logic [255:0]          efuse_key,
    output logic [31:0]           config_addr,
    output logic                  config_wr_en,
    output logic [31:0]           config_data,
    output logic                  boot_complete,
    output logic                  boot_authentic,
    output logic                  root_of_trust_established,
    output dbg_t                  dbg_state
);
    boot_state_t                 state_q, state_d;
    proto_state_t                proto_q, proto_d;
    logic [255:0]                key_q, key_d;
    logic [31:0]                 ref_q, ref_d;
    logic [31:0]                 meas_q, meas_d, meas_calc;
    logic [KEY_WORDS-1:0][31:0]  priv_q, priv_d;
    logic [KEY_WORDS-1:0][31:0]  pub_q, pub_d;
    logic [CERT_WORDS-1:0][31:0] cert_q, cert_d;
    logic                        complete_q, complete_d;
    logic                        authentic_q, authentic_d;
    logic                        rot_q, rot_d;
    logic [CNT_W-1:0]            tx_cnt_q, tx_cnt_d;
    logic                        session_q, session_d;
    logic [31:0]                 cfg_addr_q, cfg_addr_d;
    logic [31:0]                 cfg_data_q, cfg_data_d;
    logic                        cfg_wr_q, cfg_wr_d;

    logic                        ld_start;
    logic [31:0]                 ld_base;
    logic [CNT_W-1:0]            ld_count;
    logic                        ld_word_valid;
    logic [31:0]                 ld_word;
    logic [IDX_W-1:0]            ld_idx;
    logic                        ld_done;
    ld_state_t                   ld_state;
    logic                        meas_match;
    logic [IDX_W-1:0]            tx_idx;

    civic_nvram_loader u_loader (
        .clk        (clk),
        .reset      (reset),
        .start      (ld_start),
        .base       (ld_base),
        .count      (ld_count),
        .rd_en      (bus.nvram_rd_en),
        .rd_addr    (bus.nvram_rd_addr),
        .rd_data    (bus.nvram_rd_data),
        .rd_valid   (bus.nvram_rd_valid),
        .word_valid (ld_word_valid),
        .word_data  (ld_word),
        .word_idx   (ld_idx),
        .done       (ld_done),
        .state      (ld_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_KEY;
            proto_q     <= P_IDLE;
            key_q       <= '0;
            ref_q       <= '0;
            meas_q      <= '0;
            priv_q      <= '0;
            pub_q       <= '0;
            cert_q      <= '0;
            complete_q  <= 1'b0;
            authentic_q <= 1'b0;
            rot_q       <= 1'b0;
            tx_cnt_q    <= '0;
            session_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            cfg_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_q     <= proto_d;
            key_q       <= key_d;
            ref_q       <= ref_d;
            meas_q      <= meas_d;
            priv_q      <= priv_d;
            pub_q       <= pub_d;
            cert_q      <= cert_d;
            complete_q  <= complete_d;
            authentic_q <= authentic_d;
            rot_q       <= rot_d;
            tx_cnt_q    <= tx_cnt_d;
            session_q   <= session_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            cfg_wr_q    <= cfg_wr_d;
        end
    end

    // The stored private key is decrypted, so re-apply the key to recover the raw NVRAM words.
    always_comb begin
        meas_calc = '0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            meas_calc = meas_calc ^ priv_q[i] ^ key_word(key_q, 3'(i)) ^ pub_q[i];
        end
        for (int i = 0; i < CERT_WORDS; i++) begin
            meas_calc = meas_calc ^ cert_q[i];
        end
        for (int i = 0; i < 8; i++) begin
            meas_calc = meas_calc ^ key_q[i*32 +: 32];
        end
    end

    assign meas_match = (meas_calc == ref_q);

    always_comb begin
        state_d  = state_q;
        ld_start = 1'b0;
        ld_base  = '0;
        ld_count = '0;
        case (state_q)
            ST_WAIT_KEY: if (efuse_key_ready) begin
                state_d  = ST_RD_REF;
                ld_start = 1'b1;
                ld_base  = REF_ADDR;
                ld_count = CNT_W'(1);
            end
            ST_RD_REF: if (ld_done) begin
                state_d  = ST_RD_PRIV;
                ld_start = 1'b1;
                ld_base  = EK_PRIV_BASE;
                ld_count = CNT_W'(KEY_WORDS);
            end
            ST_RD_PRIV: if (ld_done) begin
                state_d  = ST_RD_PUB;
                ld_start = 1'b1;
                ld_base  = EK_PUB_BASE;
                ld_count = CNT_W'(KEY_WORDS);
            end
            ST_RD_PUB: if (ld_done) begin
                state_d  = ST_RD_CERT;
                ld_start = 1'b1;
                ld_base  = CERT_BASE;
                ld_count = CNT_W'(CERT_WORDS);
            end
            ST_RD_CERT: if (ld_done) state_d = ST_CHECK;
            ST_CHECK:   state_d = meas_match ? ST_LOG : ST_FAIL;
            ST_LOG:     state_d = ST_READY;
            ST_READY:   state_d = ST_READY;
            default:    state_d = ST_FAIL;
        endcase
    end

    always_comb begin
        key_d       = key_q;
        ref_d       = ref_q;
        priv_d      = priv_q;
        pub_d       = pub_q;
        cert_d      = cert_q;
        if ((state_q == ST_WAIT_KEY) && efuse_key_ready) key_d = efuse_key;
        if (ld_word_valid) begin
            case (state_q)
                ST_RD_REF:  ref_d          = ld_word;
                ST_RD_PRIV: priv_d[ld_idx] = ld_word ^ key_word(key_q, 3'(ld_idx));
                ST_RD_PUB:  pub_d[ld_idx]  = ld_word;
                ST_RD_CERT: cert_d[ld_idx] = ld_word;
                default:    ;
            endcase
        end
        meas_d      = (state_q == ST_CHECK) ? meas_calc : meas_q;
        complete_d  = complete_q | (state_q == ST_CHECK);
        authentic_d = authentic_q | ((state_q == ST_CHECK) && meas_match);
        rot_d       = rot_q | (state_q == ST_READY);
    end

    always_comb begin
        proto_d    = proto_q;
        tx_cnt_d   = tx_cnt_q;
        session_d  = session_q;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        cfg_wr_d   = 1'b0;
        case (proto_q)
            P_IDLE: if ((state_q == ST_READY) && bus.rx_valid) begin
                if (bus.rx_data == MSG_AUTH_REQUEST) begin
                    proto_d  = P_TX;
                    tx_cnt_d = '0;
                end else if ((bus.rx_data == MSG_CONFIG_WRITE) && session_q) begin
                    proto_d = P_ADDR;
                end else begin
                    proto_d = P_ERR;
                end
            end
            P_TX: begin
                if (tx_cnt_q == CNT_W'(CERT_WORDS)) begin
                    proto_d   = P_IDLE;
                    session_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            P_ERR: proto_d = P_IDLE;
            P_ADDR: if (bus.rx_valid) begin
                cfg_addr_d = bus.rx_data;
                proto_d    = P_DATA;
            end
            P_DATA: if (bus.rx_valid) begin
                cfg_data_d = bus.rx_data;
                cfg_wr_d   = 1'b1;
                proto_d    = P_IDLE;
            end
            default: proto_d = P_IDLE;
        endcase
    end

    assign tx_idx = IDX_W'(tx_cnt_q - CNT_W'(1));

    always_comb begin
        bus.tx_valid  = (proto_q == P_TX) || (proto_q == P_ERR);
        bus.tx_data   = '0;
        if (proto_q == P_TX) begin
            bus.tx_data = (tx_cnt_q == '0) ? MSG_CERT_RESPONSE : cert_q[tx_idx];
        end else if (proto_q == P_ERR) begin
            bus.tx_data = MSG_ERROR;
        end
        bus.nvram_wr_en   = (state_q == ST_LOG);
        bus.nvram_wr_addr = (state_q == ST_LOG) ? LOG_ADDR : '0;
        bus.nvram_wr_data = (state_q == ST_LOG) ? meas_q : '0;
        config_addr       = cfg_addr_q;
        config_data       = cfg_data_q;
        config_wr_en      = cfg_wr_q;
        boot_complete             = complete_q;
        boot_authentic            = authentic_q;
        root_of_trust_established = rot_q;
        dbg_state.boot  = state_q;
        dbg_state.ld    = ld_state;
        dbg_state.proto = proto_q;
    end

endmodule

// File: tb/tb_civic_fpga_rot_core.sv
// Directed bench for civic_fpga_rot_core: NVRAM model with random latency, scoreboard queues
// for tx words, NVRAM writes and config writes, popped by a separate negedge monitor.
module tb_civic_fpga_rot_core;
    import civic_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    civic_fpga_rot_core_if bus ();
    logic         efuse_key_ready;
    logic [255:0] efuse_key;
    logic [31:0]  config_addr, config_data;
    logic         config_wr_en, boot_complete, boot_authentic, root_of_trust_established;
    dbg_t         dbg_state;

    civic_fpga_rot_core dut (
        .clk                       (clk),
        .reset                     (reset),
        .bus                       (bus),
        .efuse_key_ready           (efuse_key_ready),
        .efuse_key                 (efuse_key),
        .config_addr               (config_addr),
        .config_wr_en              (config_wr_en),
        .config_data               (config_data),
        .boot_complete             (boot_complete),
        .boot_authentic            (boot_authentic),
        .root_of_trust_established (root_of_trust_established),
        .dbg_state                 (dbg_state)
    );

    // DEADBEEF ^ 01000100 ^ 34567890; the cert words C0DE0000..C0DE0007 XOR to zero.
    localparam logic [31:0] GOOD_REF = 32'hEBFB_C77F;
    localparam logic [255:0] KEY_A   = {224'h0, 32'h3456_7890};

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int tx_run = 0;
    int max_run = 0;
    logic [31:0] ref_word = GOOD_REF;
    logic [31:0] exp_tx_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_cfg_q[$];

    function automatic logic [31:0] nv_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return ref_word;
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        if (a == 32'h0000_2000) return 32'h0100_0100;
        if (a >= 32'h0000_3000 && a < 32'h0000_3020) return 32'hC0DE_0000 | ((a - 32'h0000_3000) >> 2);
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_strobes"}, 64'({bus.tx_valid, bus.nvram_rd_en, bus.nvram_wr_en, config_wr_en,
                                       boot_complete, boot_authentic, root_of_trust_established}), 64'h0);
        check({name, "_data"}, 64'(bus.tx_data | bus.nvram_rd_addr | bus.nvram_wr_addr |
                                   bus.nvram_wr_data | config_addr | config_data), 64'h0);
    endtask

    task automatic wait_boot(input string name);
        int n = 0;
        while (!boot_complete && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_boot_done_in_time"}, 64'(n < 3000), 64'h1);
    endtask

    task automatic start_boot(input logic [31:0] r, input logic good);
        reset = 1'b1;
        efuse_key_ready = 1'b0;
        efuse_key = KEY_A;
        tick(3);
        reset = 1'b0;
        ref_word = r;
        if (good) exp_wr_q.push_back({LOG_ADDR, GOOD_REF});
        tick(2);
        efuse_key_ready = 1'b1;
    endtask

    // NVRAM model: one-to-three cycle read latency, flags overlapping requests.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] a;
        pend = 1'b0;
        cnt = 0;
        a = '0;
        bus.nvram_rd_valid = 1'b0;
        bus.nvram_rd_data  = '0;
        forever begin
            @(negedge clk);
            bus.nvram_rd_valid = 1'b0;
            bus.nvram_rd_data  = '0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        bus.nvram_rd_valid = 1'b1;
                        bus.nvram_rd_data  = nv_word(a);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.nvram_rd_en) begin
                    check("rd_single_outstanding", 64'({pend, bus.nvram_rd_addr[1:0]}), 64'h0);
                    pend = 1'b1;
                    a = bus.nvram_rd_addr;
                    cnt = $urandom_range(0, 2);
                    rd_count++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a tx word or a write strobe.
    initial begin
        logic [31:0] e32;
        logic [63:0] e64;
        forever begin
            @(negedge clk);
            if (bus.tx_valid) begin
                tx_run++;
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%h expected=none", bus.tx_data);
                end else begin
                    e32 = exp_tx_q.pop_front();
                    check("tx_data", 64'(bus.tx_data), 64'(e32));
                end
            end else begin
                if (tx_run > max_run) max_run = tx_run;
                tx_run = 0;
            end
            if (bus.nvram_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nvram_wr_unexpected actual=%h/%h expected=none", bus.nvram_wr_addr, bus.nvram_wr_data);
                end else begin
                    e64 = exp_wr_q.pop_front();
                    check("nvram_wr", {bus.nvram_wr_addr, bus.nvram_wr_data}, e64);
                end
            end
            if (config_wr_en) begin
                if (exp_cfg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL config_wr_unexpected actual=%h/%h expected=none", config_addr, config_data);
                end else begin
                    e64 = exp_cfg_q.pop_front();
                    check("config_wr", {config_addr, config_data}, e64);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        efuse_key_ready = 1'b0;
        efuse_key = '0;
        tick(3);
        check_zero("reset");

        // Key never ready: boot must not touch NVRAM.
        reset = 1'b0;
        tick(60);
        check("no_read_without_key", 64'(rd_count), 64'h0);
        check("wait_key_state", 64'(dbg_state.boot), 64'(ST_WAIT_KEY));

        // Good boot; efuse changes after the latch must be ignored.
        start_boot(GOOD_REF, 1'b1);
        tick(3);
        efuse_key_ready = 1'b0;
        efuse_key = {256{1'b1}};
        wait_boot("good");
        tick(4);
        check("good_authentic", 64'(boot_authentic), 64'h1);
        check("good_rot", 64'(root_of_trust_established), 64'h1);
        check("good_read_count", 64'(rd_count), 64'd25);
        check("good_log_written", 64'(exp_wr_q.size()), 64'h0);

        // Before auth: each gapped word is its own opcode and each is rejected.
        repeat (3) exp_tx_q.push_back(MSG_ERROR);
        send(MSG_CONFIG_WRITE);
        tick(3);
        send(32'h0000_0010);
        tick(3);
        send(32'hCAFE_F00D);
        tick(5);
        check("noauth_errors_seen", 64'(exp_tx_q.size()), 64'h0);

        exp_tx_q.push_back(MSG_ERROR);
        send(32'h0000_0007);
        tick(3);
        check("unknown_opcode_error", 64'(exp_tx_q.size()), 64'h0);

        // AUTH burst; the words sent during the burst must be dropped.
        max_run = 0;
        exp_tx_q.push_back(MSG_CERT_RESPONSE);
        for (int i = 0; i < CERT_WORDS; i++) exp_tx_q.push_back(32'hC0DE_0000 | i);
        send(MSG_AUTH_REQUEST);
        send(32'h0000_0055);
        send(MSG_CONFIG_WRITE);
        tick(15);
        check("auth_burst_done", 64'(exp_tx_q.size()), 64'h0);
        check("auth_burst_consecutive", 64'(max_run), 64'd9);

        // Config write inside the session.
        exp_cfg_q.push_back({32'h0000_0010, 32'hCAFE_F00D});
        send(MSG_CONFIG_WRITE);
        tick(2);
        send(32'h0000_0010);
        tick(2);
        send(32'hCAFE_F00D);
        tick(4);
        check("config_done", 64'(exp_cfg_q.size()), 64'h0);
        check("config_addr_held", 64'(config_addr), 64'h10);

        // Wrong reference: terminal FAIL, no log write, rx ignored.
        start_boot(GOOD_REF ^ 32'h1, 1'b0);
        wait_boot("bad");
        tick(5);
        check("bad_complete", 64'(boot_complete), 64'h1);
        check("bad_authentic", 64'(boot_authentic), 64'h0);
        check("bad_rot", 64'(root_of_trust_established), 64'h0);
        check("bad_fail_state", 64'(dbg_state.boot), 64'(ST_FAIL));
        send(MSG_AUTH_REQUEST);
        tick(15);

        // Reset in the middle of the public-key reads, then a clean rerun.
        start_boot(GOOD_REF, 1'b0);
        n = 0;
        while (dbg_state.boot != ST_RD_PUB && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_rd_pub", 64'(n < 2000), 64'h1);
        tick(2);
        reset = 1'b1;
        #1;
        check_zero("mid_pub_reset");
        check("mid_pub_reset_state", 64'(dbg_state.boot), 64'(ST_WAIT_KEY));
        @(negedge clk);
        start_boot(GOOD_REF, 1'b1);
        wait_boot("rerun");
        tick(4);
        check("rerun_authentic", 64'(boot_authentic), 64'h1);
        check("rerun_rot", 64'(root_of_trust_established), 64'h1);
        check("final_queues_empty", 64'(exp_tx_q.size() + exp_wr_q.size() + exp_cfg_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
